// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// default NOP/HALT constants (also used by decode) and small PC/opcode helpers.
package fetch_stage_pkg;

  // Fetch FSM state encodings
  localparam logic [1:0] FS_REQ  = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_HOLD = 2'd2;
  localparam logic [1:0] FS_HALT = 2'd3;

  // Instruction constants shared with decode
  localparam logic [15:0] NOP_INSTR_DEF   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE_DEF = 5'b00000;

  // Sequential PC increment; 16-bit modulo, carry out discarded
  function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  // True when the instruction opcode field matches the halt opcode
  function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] op);
    return (instr[15:11] == op);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// 16-bit program counter register with synchronous active-low reset and
// a load enable; the caller supplies the next value.
module fetch_stage_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] d,
  output logic [15:0] q
);

  // PC storage: reset to RESET_PC, load d when enabled, otherwise hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, sequences single 16-bit fetches from a
// multi-cycle instruction memory and fills the IF/ID register.
// Optional feature macro: FETCH_ALIGN_CHK_EN (misaligned-PC detection, sticky err).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = NOP_INSTR_DEF,
  parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic        if_id_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_incr_pc,
  output logic        halted,
  output logic        err
);

  logic [1:0]  state_r;
  logic        squash_r;
  logic [15:0] hold_instr_r;
  logic [15:0] pc_q_s;

  logic [1:0]  state_nxt_s;
  logic        squash_nxt_s;
  logic        pc_en_s;
  logic [15:0] pc_d_s;
  logic        load_s;
  logic [15:0] load_instr_s;
  logic        hold_cap_s;
  logic        req_nxt_s;
  logic        halted_nxt_s;
  logic        err_nxt_s;

  fetch_stage_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_en_s),
    .d     (pc_d_s),
    .q     (pc_q_s)
  );

  // Next-state decode: redirect first, then per-state fetch sequencing
  always_comb begin
    state_nxt_s  = state_r;
    squash_nxt_s = squash_r;
    pc_en_s      = 1'b0;
    pc_d_s       = pc_q_s;
    load_s       = 1'b0;
    load_instr_s = hold_instr_r;
    hold_cap_s   = 1'b0;
    req_nxt_s    = 1'b0;
    halted_nxt_s = halted;
`ifdef FETCH_ALIGN_CHK_EN
    err_nxt_s    = err;
`else
    err_nxt_s    = 1'b0;
`endif
    if (redirect) begin
      pc_en_s      = 1'b1;
      pc_d_s       = redirect_pc;
      halted_nxt_s = 1'b0;
      if ((state_r == FS_WAIT) && !imem_done) begin
        // response still outstanding: drop it when it arrives
        squash_nxt_s = 1'b1;
        state_nxt_s  = FS_WAIT;
      end else begin
        squash_nxt_s = 1'b0;
        state_nxt_s  = FS_REQ;
      end
    end else begin
      case (state_r)
        FS_REQ: begin
`ifdef FETCH_ALIGN_CHK_EN
          if (pc_q_s[0]) begin
            err_nxt_s    = 1'b1;
            halted_nxt_s = 1'b1;
            state_nxt_s  = FS_HALT;
          end else begin
            req_nxt_s   = 1'b1;
            state_nxt_s = FS_WAIT;
          end
`else
          req_nxt_s   = 1'b1;
          state_nxt_s = FS_WAIT;
`endif
        end
        FS_WAIT: begin
          if (!imem_done) begin
            state_nxt_s = FS_WAIT;
          end else if (squash_r) begin
            squash_nxt_s = 1'b0;
            state_nxt_s  = FS_REQ;
          end else if (!if_id_valid || !id_stall) begin
            load_s       = 1'b1;
            load_instr_s = imem_rdata;
          end else begin
            hold_cap_s  = 1'b1;
            state_nxt_s = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (!id_stall) begin
            load_s       = 1'b1;
            load_instr_s = hold_instr_r;
          end else begin
            state_nxt_s = FS_HOLD;
          end
        end
        FS_HALT: begin
          state_nxt_s  = FS_HALT;
          halted_nxt_s = 1'b1;
        end
        default: begin
          state_nxt_s = FS_REQ;
        end
      endcase
      // A loaded halt instruction freezes the PC; anything else advances it
      if (load_s) begin
        if (is_halt(load_instr_s, HALT_OPCODE)) begin
          halted_nxt_s = 1'b1;
          state_nxt_s  = FS_HALT;
        end else begin
          pc_en_s     = 1'b1;
          pc_d_s      = pc_plus2(pc_q_s);
          state_nxt_s = FS_REQ;
        end
      end else begin
        pc_d_s = pc_q_s;
      end
    end
  end

  // State, request, hold and IF/ID registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= FS_REQ;
      squash_r      <= 1'b0;
      hold_instr_r  <= NOP_INSTR;
      imem_req      <= 1'b0;
      imem_addr     <= 16'h0000;
      if_id_valid   <= 1'b0;
      if_id_instr   <= NOP_INSTR;
      if_id_pc      <= 16'h0000;
      if_id_incr_pc <= 16'h0000;
      halted        <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      squash_r <= squash_nxt_s;
      imem_req <= req_nxt_s;
      halted   <= halted_nxt_s;
      err      <= err_nxt_s;
      if (req_nxt_s) begin
        imem_addr <= {pc_q_s[15:1], 1'b0};
      end
      if (hold_cap_s) begin
        hold_instr_r <= imem_rdata;
      end
      if (redirect) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (load_s) begin
        if_id_valid   <= 1'b1;
        if_id_instr   <= load_instr_s;
        if_id_pc      <= pc_q_s;
        if_id_incr_pc <= pc_plus2(pc_q_s);
      end else if (!id_stall) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the memory side is driven
// by hand from each scenario task.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        id_stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        imem_done = 1'b0;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_incr_pc;
  logic        halted;
  logic        err;

  int compared = 0;
  int mismatched = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_stall(id_stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_done(imem_done), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_incr_pc(if_id_incr_pc),
    .halted(halted), .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle memory response strobe
  task automatic mem_respond(input logic [15:0] data);
    imem_done  = 1'b1;
    imem_rdata = data;
    step();
    imem_done  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", imem_req); end
    compared++; if (if_id_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", if_id_valid); end
    compared++; if (if_id_instr !== 16'h0800) begin mismatched++; $display("FAIL reset_instr: got %h want 0800", if_id_instr); end
    compared++; if ({if_id_pc, if_id_incr_pc} !== 32'h0) begin mismatched++; $display("FAIL reset_pcs: got %h/%h want 0/0", if_id_pc, if_id_incr_pc); end
    compared++; if ({halted, err} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got halted=%b err=%b want 0/0", halted, err); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin mismatched++; $display("FAIL first_req: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    step();
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL req_pulse: got %b want 0", imem_req); end
    mem_respond(16'h4001);
    compared++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc} !== {1'b1, 16'h4001, 16'h0000, 16'h0002})
      begin mismatched++; $display("FAIL first_load: got v=%b i=%h pc=%h inc=%h want 1/4001/0000/0002", if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin mismatched++; $display("FAIL second_req: got req=%b addr=%h want 1/0002", imem_req, imem_addr); end
    compared++; if ({if_id_valid, if_id_instr} !== {1'b0, 16'h0800}) begin mismatched++; $display("FAIL consume: got v=%b i=%h want 0/0800", if_id_valid, if_id_instr); end
  endtask

  task automatic test_stall_hold();
    step();
    id_stall = 1'b1;
    mem_respond(16'h1111);
    compared++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h1111, 16'h0002}) begin mismatched++; $display("FAIL stall_free_load: got v=%b i=%h pc=%h want 1/1111/0002", if_id_valid, if_id_instr, if_id_pc); end
    step();
    compared++; if ({imem_req, imem_addr, if_id_instr} !== {1'b1, 16'h0004, 16'h1111}) begin mismatched++; $display("FAIL stall_req: got req=%b addr=%h i=%h want 1/0004/1111", imem_req, imem_addr, if_id_instr); end
    step();
    mem_respond(16'hC123);
    for (int i = 0; i < 2; i++) begin
      step();
      compared++; if ({imem_req, if_id_valid, if_id_instr} !== {1'b0, 1'b1, 16'h1111}) begin mismatched++; $display("FAIL hold_wait: got req=%b v=%b i=%h want 0/1/1111", imem_req, if_id_valid, if_id_instr); end
    end
    id_stall = 1'b0;
    step();
    compared++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc} !== {1'b1, 16'hC123, 16'h0004, 16'h0006})
      begin mismatched++; $display("FAIL hold_load: got v=%b i=%h pc=%h inc=%h want 1/c123/0004/0006", if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) begin mismatched++; $display("FAIL hold_next_req: got req=%b addr=%h want 1/0006", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    compared++; if (imem_req !== 1'b0) begin mismatched++; $display("FAIL squash_noreq: got %b want 0", imem_req); end
    step();
    mem_respond(16'h7777);
    compared++; if ({if_id_valid, if_id_instr} !== {1'b0, 16'h0800}) begin mismatched++; $display("FAIL squash_discard: got v=%b i=%h want 0/0800", if_id_valid, if_id_instr); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) begin mismatched++; $display("FAIL squash_req: got req=%b addr=%h want 1/0040", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_done();
    step();
    redirect = 1'b1; redirect_pc = 16'h0100;
    imem_done = 1'b1; imem_rdata = 16'h2222;
    step();
    redirect = 1'b0; imem_done = 1'b0;
    compared++; if ({imem_req, if_id_valid} !== 2'b00) begin mismatched++; $display("FAIL rd_drop: got req=%b v=%b want 0/0", imem_req, if_id_valid); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0100}) begin mismatched++; $display("FAIL rd_req: got req=%b addr=%h want 1/0100", imem_req, imem_addr); end
    step();
    mem_respond(16'h3333);
    compared++; if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, 16'h3333, 16'h0100}) begin mismatched++; $display("FAIL rd_after: got v=%b i=%h pc=%h want 1/3333/0100", if_id_valid, if_id_instr, if_id_pc); end
  endtask

  task automatic test_halt();
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0010}) begin mismatched++; $display("FAIL halt_req: got req=%b addr=%h want 1/0010", imem_req, imem_addr); end
    step();
    mem_respond(16'h0000);
    compared++; if ({if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc, halted} !== {1'b1, 16'h0000, 16'h0010, 16'h0012, 1'b1})
      begin mismatched++; $display("FAIL halt_load: got v=%b i=%h pc=%h inc=%h h=%b want 1/0000/0010/0012/1", if_id_valid, if_id_instr, if_id_pc, if_id_incr_pc, halted); end
    id_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++; if ({imem_req, halted} !== 2'b01) begin mismatched++; $display("FAIL halt_idle: got req=%b h=%b want 0/1", imem_req, halted); end
    end
    mem_respond(16'h5555);
    compared++; if ({if_id_valid, if_id_instr, imem_req} !== {1'b1, 16'h0000, 1'b0}) begin mismatched++; $display("FAIL halt_stray_done: got v=%b i=%h req=%b want 1/0000/0", if_id_valid, if_id_instr, imem_req); end
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0; id_stall = 1'b0;
    compared++; if ({if_id_valid, if_id_instr, halted} !== {1'b0, 16'h0800, 1'b0}) begin mismatched++; $display("FAIL halt_flush: got v=%b i=%h h=%b want 0/0800/0", if_id_valid, if_id_instr, halted); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0020}) begin mismatched++; $display("FAIL halt_resume: got req=%b addr=%h want 1/0020", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_align();
    step();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    mem_respond(16'h9999);
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'hFFFE}) begin mismatched++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffe", imem_req, imem_addr); end
    step();
    mem_respond(16'h4444);
    compared++; if ({if_id_pc, if_id_incr_pc} !== {16'hFFFE, 16'h0000}) begin mismatched++; $display("FAIL wrap_incr: got pc=%h inc=%h want fffe/0000", if_id_pc, if_id_incr_pc); end
    step();
    compared++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin mismatched++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 16'h0013;
    step();
    redirect = 1'b0;
    mem_respond(16'h9999);
    step();
`ifdef FETCH_ALIGN_CHK_EN
    compared++; if ({imem_req, err, halted} !== 3'b011) begin mismatched++; $display("FAIL align_err: got req=%b err=%b h=%b want 0/1/1", imem_req, err, halted); end
    redirect = 1'b1; redirect_pc = 16'h0030;
    step();
    redirect = 1'b0;
    compared++; if ({err, halted} !== 2'b10) begin mismatched++; $display("FAIL align_sticky: got err=%b h=%b want 1/0", err, halted); end
`else
    compared++; if ({imem_req, imem_addr, err} !== {1'b1, 16'h0012, 1'b0}) begin mismatched++; $display("FAIL align_mask: got req=%b addr=%h err=%b want 1/0012/0", imem_req, imem_addr, err); end
`endif
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_done();
    test_halt();
    test_wrap_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
